eth_fll_cfg: RTL
================

# eth_fll_cfg

Configuration initiator for the Ethernet 125 MHz clock FLL. After reset, or on a `start_i` request, it programs the FLL's three configuration registers over the FLL's 4-phase req/ack configuration port. It then polls the FLL status register until the measured multiplication factor stays within tolerance of the target, and reports locked or error. It sits next to the Ethernet clock generator and drives the configuration port that is otherwise left unconnected.

## Interface
Parameters:
- `CFG1_VAL`, 32'h0, value written to FLL address 1 (config 1)
- `CFG2_VAL`, 32'h0, value written to FLL address 2 (config 2)
- `INTEG_VAL`, 32'h0, value written to FLL address 3 (integrator)
- `TARGET_MF`, 16'd0, expected multiplication factor in status[15:0]
- `MF_TOL`, 16'd4, allowed absolute deviation from `TARGET_MF`
- `LOCK_CNT`, 4, consecutive in-tolerance reads required for lock (≥1)
- `POLL_WAIT`, 256, idle cycles before each status read (≥1)
- `MAX_POLLS`, 64, status reads allowed before a lock timeout
- `ACK_TIMEOUT`, 32, cycles allowed per handshake phase

Ports:
- `clk_i` in 1 — clock
- `rst_i` in 1 — reset; one clock, asynchronous, active-high
- `start_i` in 1 — single-cycle restart request; honoured only in DONE or ERROR
- `cfg_req_o` out 1 — configuration access request
- `cfg_ack_i` in 1 — configuration access grant from the FLL
- `cfg_addr_o` out 2 — register address
- `cfg_wdata_o` out 32 — write data
- `cfg_we_no` out 1 — write enable, active-low
- `cfg_rdata_i` in 32 — read data, valid while `cfg_ack_i` is high during a read
- `busy_o` out 1 — sequence in progress
- `done_o` out 1 — sequence finished successfully
- `locked_o` out 1 — FLL lock confirmed
- `error_o` out 1 — sequence aborted
- `err_code_o` out 2 — 0 none, 1 ack timeout, 2 lock timeout
- `mf_o` out 16 — last sampled status[15:0]

## Operation
- States: IDLE, WR_REQ, WR_REL, WAIT, RD_REQ, RD_REL, CHECK, DONE, ERROR.
- IDLE is entered only by reset. It always advances to WR_REQ with write index 0.
- Write sequence: addresses 1, 2, 3 with data `CFG1_VAL`, `CFG2_VAL`, `INTEG_VAL`, in that order.
- Handshake, identical for reads and writes:
  - REQ phase: `cfg_req_o`=1 with addr, wdata and we_n held stable until `cfg_ack_i` is sampled high.
  - REL phase: `cfg_req_o`=0, then wait for `cfg_ack_i` to be sampled low.
  - A new request is never raised while `cfg_ack_i` is high.
- After the third write: WAIT counts `POLL_WAIT` cycles, then RD_REQ reads address 0 with `cfg_we_no`=1 and `cfg_wdata_o`=0.
- Read capture: `mf_o` ← `cfg_rdata_i[15:0]` in the cycle `cfg_ack_i` is sampled high.
- CHECK:
  - Deviation is |mf − `TARGET_MF`|, computed in 17-bit signed and compared unsigned against `MF_TOL`. Equal to `MF_TOL` counts as in tolerance.
  - In tolerance: the consecutive-hit counter increments. Out of tolerance: the counter clears to 0.
  - Counter = `LOCK_CNT` → DONE, with `locked_o`=1 and `done_o`=1.
  - Otherwise, if reads issued = `MAX_POLLS` → ERROR, code 2.
  - Otherwise → WAIT.
- Ack timeout: a per-phase counter resets on each phase entry. Reaching `ACK_TIMEOUT` in any REQ or REL phase → ERROR, code 1, with `cfg_req_o` forced to 0.
- `busy_o`=1 in every state except IDLE, DONE and ERROR.
- DONE and ERROR are sticky. `start_i`=1 in either state:
  - clears `done_o`, `locked_o`, `error_o` and `err_code_o`;
  - resets the poll and hit counters;
  - goes to WR_REQ index 0;
  - leaves `mf_o` unchanged.
- `start_i` in any other state is ignored.
- Reset mid-operation: all state clears immediately and `cfg_req_o` drops asynchronously. The FLL side is expected to release its ack on its own.

## Timing
- Reset values: `cfg_req_o`=0, `cfg_we_no`=1, `cfg_addr_o`=0, `cfg_wdata_o`=0, `busy_o`=0, `done_o`=0, `locked_o`=0, `error_o`=0, `err_code_o`=0, `mf_o`=0.
- All outputs are registered.
- First clk edge with `rst_i` low: IDLE→WR_REQ. `cfg_req_o`=1, `busy_o`=1 and `cfg_addr_o`=1 from that edge.
- Ack high sampled at edge N: `cfg_req_o`=0 from edge N.
- Ack low sampled at edge M: the next request is raised at edge M, or WAIT is entered at edge M.
- Minimum of 2 cycles per transaction with a 1-cycle responder.
- CHECK takes 1 cycle. `done_o`/`locked_o`/`error_o` rise on the edge leaving CHECK, or on the timeout edge.

## Test plan
- Nominal, ack one cycle after req, status=`TARGET_MF`, `LOCK_CNT`=4 → writes to addr 1/2/3 with the parameter data, exactly 4 reads, `done_o`=`locked_o`=1, `err_code_o`=0.
- Status alternates `TARGET_MF`+`MF_TOL` / `TARGET_MF`+`MF_TOL`+1 → hits never accumulate to lock; after `MAX_POLLS` reads `error_o`=1, `err_code_o`=2, `locked_o`=0.
- Ack held low during the second write → `cfg_req_o` falls at `ACK_TIMEOUT`, `err_code_o`=1. Ack stuck high after the read grant → also `err_code_o`=1.
- Ack held high 5 cycles after grant → no new req until ack is sampled low. Check wdata/addr stability during REQ.
- `start_i` pulsed mid-write → ignored. `start_i` pulsed in ERROR → flags clear next edge and the full sequence repeats to lock.
- `rst_i` asserted during RD_REQ → outputs return to reset values asynchronously. After release, the sequence restarts from addr 1.

Source files
------------

// File: rtl/eth_fll_cfg.sv
// Configuration initiator for the Ethernet 125 MHz clock FLL: writes the three
// config registers over the req/ack port, then polls status until lock or error.
module eth_fll_cfg #(
    parameter logic [31:0] CFG1_VAL    = 32'h0,
    parameter logic [31:0] CFG2_VAL    = 32'h0,
    parameter logic [31:0] INTEG_VAL   = 32'h0,
    parameter logic [15:0] TARGET_MF   = 16'd0,
    parameter logic [15:0] MF_TOL      = 16'd4,
    parameter int          LOCK_CNT    = 4,
    parameter int          POLL_WAIT   = 256,
    parameter int          MAX_POLLS   = 64,
    parameter int          ACK_TIMEOUT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        cfg_req_o,
    input  logic        cfg_ack_i,
    output logic [1:0]  cfg_addr_o,
    output logic [31:0] cfg_wdata_o,
    output logic        cfg_we_no,
    input  logic [31:0] cfg_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        locked_o,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] mf_o
);

    localparam int TIMER_MAX = (POLL_WAIT > ACK_TIMEOUT) ? POLL_WAIT : ACK_TIMEOUT;
    localparam int TW = $clog2(TIMER_MAX + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam int HW = $clog2(LOCK_CNT + 1);

    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(POLL_WAIT - 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
    localparam logic [HW-1:0] HIT_LIMIT  = HW'(LOCK_CNT);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ACK  = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_REQ, ST_WR_REL, ST_WAIT, ST_RD_REQ,
        ST_RD_REL, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;

    state_t          state_reg;
    logic [1:0]      wr_idx_reg;
    logic [TW-1:0]   timer_reg;
    logic [PW-1:0]   poll_cnt_reg;
    logic [HW-1:0]   hit_cnt_reg;

    logic signed [16:0] mf_diff;
    logic [16:0]        mf_dev;
    logic               in_tol;
    logic [HW-1:0]      hit_next;
    logic               unused_rdata_hi;

    function automatic logic [31:0] wr_data(input logic [1:0] idx);
        case (idx)
            2'd0:    wr_data = CFG1_VAL;
            2'd1:    wr_data = CFG2_VAL;
            default: wr_data = INTEG_VAL;
        endcase
    endfunction

    // Deviation uses the captured mf, so CHECK sees the value of the last read
    assign mf_diff  = $signed({1'b0, mf_o}) - $signed({1'b0, TARGET_MF});
    assign mf_dev   = mf_diff[16] ? -mf_diff : mf_diff;
    assign in_tol   = (mf_dev <= {1'b0, MF_TOL});
    assign hit_next = in_tol ? HW'(hit_cnt_reg + 1'b1) : '0;

    assign unused_rdata_hi = ^cfg_rdata_i[31:16];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            wr_idx_reg   <= 2'd0;
            timer_reg    <= '0;
            poll_cnt_reg <= '0;
            hit_cnt_reg  <= '0;
            cfg_req_o    <= 1'b0;
            cfg_addr_o   <= 2'd0;
            cfg_wdata_o  <= 32'h0;
            cfg_we_no    <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            locked_o     <= 1'b0;
            error_o      <= 1'b0;
            err_code_o   <= ERR_NONE;
            mf_o         <= 16'h0;
        end else begin
            unique case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (state_reg == ST_IDLE || start_i) begin
                        state_reg    <= ST_WR_REQ;
                        wr_idx_reg   <= 2'd0;
                        timer_reg    <= '0;
                        poll_cnt_reg <= '0;
                        hit_cnt_reg  <= '0;
                        cfg_req_o    <= 1'b1;
                        cfg_addr_o   <= 2'd1;
                        cfg_wdata_o  <= CFG1_VAL;
                        cfg_we_no    <= 1'b0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        locked_o     <= 1'b0;
                        error_o      <= 1'b0;
                        err_code_o   <= ERR_NONE;
                    end
                end

                ST_WR_REQ, ST_RD_REQ: begin
                    if (cfg_ack_i) begin
                        cfg_req_o <= 1'b0;
                        timer_reg <= '0;
                        if (state_reg == ST_RD_REQ) begin
                            mf_o      <= cfg_rdata_i[15:0];
                            state_reg <= ST_RD_REL;
                        end else begin
                            state_reg <= ST_WR_REL;
                        end
                    end else if (timer_reg == ACK_LAST) begin
                        state_reg  <= ST_ERROR;
                        cfg_req_o  <= 1'b0;
                        busy_o     <= 1'b0;
                        error_o    <= 1'b1;
                        err_code_o <= ERR_ACK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_WR_REL, ST_RD_REL: begin
                    if (!cfg_ack_i) begin
                        timer_reg <= '0;
                        if (state_reg == ST_RD_REL) begin
                            state_reg <= ST_CHECK;
                        end else if (wr_idx_reg == 2'd2) begin
                            state_reg <= ST_WAIT;
                        end else begin
                            state_reg   <= ST_WR_REQ;
                            wr_idx_reg  <= wr_idx_reg + 2'd1;
                            cfg_req_o   <= 1'b1;
                            cfg_addr_o  <= wr_idx_reg + 2'd2;
                            cfg_wdata_o <= wr_data(wr_idx_reg + 2'd1);
                        end
                    end else if (timer_reg == ACK_LAST) begin
                        state_reg  <= ST_ERROR;
                        busy_o     <= 1'b0;
                        error_o    <= 1'b1;
                        err_code_o <= ERR_ACK;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_WAIT: begin
                    // The read is also held back while a stale ack is still high
                    if (timer_reg == WAIT_LAST) begin
                        if (!cfg_ack_i) begin
                            state_reg    <= ST_RD_REQ;
                            timer_reg    <= '0;
                            poll_cnt_reg <= poll_cnt_reg + 1'b1;
                            cfg_req_o    <= 1'b1;
                            cfg_addr_o   <= 2'd0;
                            cfg_wdata_o  <= 32'h0;
                            cfg_we_no    <= 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_CHECK: begin
                    hit_cnt_reg <= hit_next;
                    timer_reg   <= '0;
                    if (hit_next == HIT_LIMIT) begin
                        state_reg <= ST_DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        locked_o  <= 1'b1;
                    end else if (poll_cnt_reg == POLL_LIMIT) begin
                        state_reg  <= ST_ERROR;
                        busy_o     <= 1'b0;
                        error_o    <= 1'b1;
                        err_code_o <= ERR_LOCK;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
